// File: rtl/gb_px_sink_if.sv
// Pixel-sink bus: PPU pixel stream and palette in, framebuffer write port and status out.
interface gb_px_sink_if;
    localparam int unsigned ADDR_W = 14;
    localparam int unsigned DATA_W = 8;

    logic [1:0]        px_in;
    logic              px_valid;
    logic [1:0]        ppu_mode;
    logic [7:0]        bgp;
    logic              fb_wr;
    logic [ADDR_W-1:0] fb_addr;
    logic [DATA_W-1:0] fb_wdata;
    logic              fb_wready;
    logic              frame_done;
    logic              bank;
    logic              overflow;
    logic              ovf_clr;

    modport master (
        output px_in, px_valid, ppu_mode, bgp, fb_wready, ovf_clr,
        input  fb_wr, fb_addr, fb_wdata, frame_done, bank, overflow
    );

    modport slave (
        input  px_in, px_valid, ppu_mode, bgp, fb_wready, ovf_clr,
        output fb_wr, fb_addr, fb_wdata, frame_done, bank, overflow
    );
endinterface

// File: rtl/gb_px_sink.sv
// PPU pixel sink: palette map, 4-pixel byte packing, position tracking and a small
// write FIFO into a double-buffered framebuffer that swaps banks at V_BLANK.
module gb_px_sink #(
    parameter int unsigned H_PIXELS   = 160,
    parameter int unsigned V_LINES    = 144,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    gb_px_sink_if.slave bus
);
    localparam int unsigned XW = 8;
    localparam int unsigned LW = 8;
    localparam int unsigned OW = 13;
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;

    localparam logic [XW-1:0] X_MAX      = XW'(H_PIXELS);
    localparam logic [LW-1:0] L_MAX      = LW'(V_LINES);
    localparam logic [OW-1:0] LINE_BYTES = OW'(H_PIXELS / 4);
    localparam logic [CW-1:0] DEPTH_C    = CW'(FIFO_DEPTH);

    localparam logic [1:0] MODE_HBLANK = 2'd0;
    localparam logic [1:0] MODE_VBLANK = 2'd1;
    localparam logic [1:0] MODE_DRAW   = 2'd3;

    logic [XW-1:0] x_q, x_d;
    logic [LW-1:0] line_q, line_d;
    logic [5:0]    pack_q, pack_d;
    logic [OW-1:0] addr_q, addr_d;
    logic [OW-1:0] line_base_q, line_base_d;
    logic [1:0]    prev_mode_q, prev_mode_d;
    logic          bank_q, bank_d;
    logic          swap_pending_q, swap_pending_d;
    logic          frame_done_q, frame_done_d;
    logic          overflow_q, overflow_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    mem_data_q [FIFO_DEPTH];
    logic [7:0]    mem_data_d [FIFO_DEPTH];
    logic [OW-1:0] mem_off_q  [FIFO_DEPTH];
    logic [OW-1:0] mem_off_d  [FIFO_DEPTH];

    logic [1:0] shade;
    logic       pop;
    logic       eol;
    logic       push;
    logic       push_ok;
    logic       set_ovf;
    logic [7:0] push_data;

    // Palette lookup uses the bgp value present with this pixel
    always_comb begin
        case (bus.px_in)
            2'd0:    shade = bus.bgp[1:0];
            2'd1:    shade = bus.bgp[3:2];
            2'd2:    shade = bus.bgp[5:4];
            default: shade = bus.bgp[7:6];
        endcase
    end

    assign pop = (count_q != '0) && bus.fb_wready;
    assign eol = (prev_mode_q == MODE_DRAW) && (bus.ppu_mode == MODE_HBLANK);

    always_comb begin
        x_d            = x_q;
        line_d         = line_q;
        pack_d         = pack_q;
        addr_d         = addr_q;
        line_base_d    = line_base_q;
        prev_mode_d    = bus.ppu_mode;
        bank_d         = bank_q;
        swap_pending_d = swap_pending_q;
        frame_done_d   = 1'b0;
        overflow_d     = overflow_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        count_d        = count_q;
        mem_data_d     = mem_data_q;
        mem_off_d      = mem_off_q;
        push           = 1'b0;
        push_ok        = 1'b0;
        push_data      = '0;
        set_ovf        = 1'b0;

        if (bus.px_valid && bus.ppu_mode == MODE_DRAW) begin
            if (x_q < X_MAX && line_q < L_MAX) begin
                x_d = x_q + XW'(1);
                if (x_q[1:0] == 2'd3) begin
                    push      = 1'b1;
                    push_data = {pack_q, shade};
                    pack_d    = '0;
                    addr_d    = addr_q + OW'(1);
                end else begin
                    pack_d = {pack_q[3:0], shade};
                end
            end else begin
                set_ovf = 1'b1;
            end
        end

        // Flush a partial byte left-aligned, then jump to the next line's base
        if (eol) begin
            case (x_q[1:0])
                2'd1:    push_data = {pack_q[1:0], 6'b0};
                2'd2:    push_data = {pack_q[3:0], 4'b0};
                2'd3:    push_data = {pack_q, 2'b0};
                default: push_data = '0;
            endcase
            push   = (x_q[1:0] != 2'd0);
            pack_d = '0;
            x_d    = '0;
            if (line_q < L_MAX) begin
                line_d      = line_q + LW'(1);
                line_base_d = line_base_q + LINE_BYTES;
                addr_d      = line_base_q + LINE_BYTES;
            end
        end

        push_ok = push && (count_q < DEPTH_C);
        if (push && !push_ok) begin
            set_ovf = 1'b1;
        end
        if (push_ok) begin
            mem_data_d[wr_ptr_q] = push_data;
            mem_off_d[wr_ptr_q]  = addr_q;
            wr_ptr_d             = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push_ok && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push_ok && pop) begin
            count_d = count_q - CW'(1);
        end

        // Bank swap waits until every byte of the finished frame has drained
        if (prev_mode_q != MODE_VBLANK && bus.ppu_mode == MODE_VBLANK) begin
            swap_pending_d = 1'b1;
        end
        if (swap_pending_q && count_q == '0 && !push) begin
            bank_d         = ~bank_q;
            frame_done_d   = 1'b1;
            swap_pending_d = 1'b0;
            x_d            = '0;
            line_d         = '0;
            pack_d         = '0;
            addr_d         = '0;
            line_base_d    = '0;
        end

        overflow_d = set_ovf ? 1'b1 : (bus.ovf_clr ? 1'b0 : overflow_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q            <= '0;
            line_q         <= '0;
            pack_q         <= '0;
            addr_q         <= '0;
            line_base_q    <= '0;
            prev_mode_q    <= '0;
            bank_q         <= 1'b0;
            swap_pending_q <= 1'b0;
            frame_done_q   <= 1'b0;
            overflow_q     <= 1'b0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_data_q[i] <= '0;
                mem_off_q[i]  <= '0;
            end
        end else begin
            x_q            <= x_d;
            line_q         <= line_d;
            pack_q         <= pack_d;
            addr_q         <= addr_d;
            line_base_q    <= line_base_d;
            prev_mode_q    <= prev_mode_d;
            bank_q         <= bank_d;
            swap_pending_q <= swap_pending_d;
            frame_done_q   <= frame_done_d;
            overflow_q     <= overflow_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            mem_data_q     <= mem_data_d;
            mem_off_q      <= mem_off_d;
        end
    end

    assign bus.fb_wr      = (count_q != '0);
    assign bus.fb_addr    = {bank_q, mem_off_q[rd_ptr_q]};
    assign bus.fb_wdata   = mem_data_q[rd_ptr_q];
    assign bus.frame_done = frame_done_q;
    assign bus.bank       = bank_q;
    assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_gb_px_sink.sv
// Bench for gb_px_sink: palette vectors, directed corner sequences and a random frame
// checked against a line-level packing model.
module tb_gb_px_sink;
    logic clk;
    logic rst;

    gb_px_sink_if bus ();

    gb_px_sink #(
        .H_PIXELS  (160),
        .V_LINES   (144),
        .FIFO_DEPTH(4)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [7:0] bgp;
        logic [7:0] px;
        logic [7:0] exp;
    } vec_t;

    int checks;
    int failures;
    int fd_cycles;
    int fd_at_writes;
    int low_run;
    bit ready_rand;

    logic [13:0] got_addr [$];
    logic [7:0]  got_data [$];
    logic [13:0] exp_addr [$];
    logic [7:0]  exp_data [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // A transfer is committed at the next rising edge when both are high here
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.fb_wr && bus.fb_wready) begin
                got_addr.push_back(bus.fb_addr);
                got_data.push_back(bus.fb_wdata);
            end
            if (bus.frame_done) begin
                fd_cycles++;
                fd_at_writes = got_addr.size();
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        if (ready_rand) begin
            if (low_run >= 2 || $urandom_range(0, 3) != 0) begin
                bus.fb_wready = 1'b1;
                low_run = 0;
            end else begin
                bus.fb_wready = 1'b0;
                low_run++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_px(input logic [1:0] p);
        bus.px_in    = p;
        bus.px_valid = 1'b1;
        tick();
        bus.px_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.px_valid  = 1'b0;
        bus.px_in     = 2'd0;
        bus.ppu_mode  = 2'd0;
        bus.ovf_clr   = 1'b0;
        bus.fb_wready = 1'b1;
        ready_rand    = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        got_addr.delete();
        got_data.delete();
        fd_cycles    = 0;
        fd_at_writes = 0;
    endtask

    task automatic got_at(input int i, output logic [13:0] a, output logic [7:0] d);
        if (i < got_addr.size()) begin
            a = got_addr[i];
            d = got_data[i];
        end else begin
            a = 14'h3fff;
            d = 8'hxx;
        end
    endtask

    function automatic logic [1:0] shade_of(input logic [7:0] pal, input logic [1:0] p);
        logic [7:0] s;
        s = pal >> (32'(p) * 2);
        return s[1:0];
    endfunction

    // One line with random gaps and a random palette per pixel; expected bytes queued
    task automatic run_line(input int n, input int lnum, input logic bnk);
        logic [1:0] sh [$];
        logic [1:0] p;
        logic [7:0] v;
        int cnt;
        bus.ppu_mode = 2'd2;
        repeat (3) begin
            bus.px_valid = 1'($urandom_range(0, 1));
            bus.px_in    = 2'($urandom);
            tick();
        end
        bus.ppu_mode = 2'd3;
        cnt = 0;
        while (cnt < n) begin
            if ($urandom_range(0, 7) != 0) begin
                p            = 2'($urandom);
                bus.bgp      = 8'($urandom);
                bus.px_in    = p;
                bus.px_valid = 1'b1;
                sh.push_back(shade_of(bus.bgp, p));
                cnt++;
            end else begin
                bus.px_valid = 1'b0;
                bus.px_in    = 2'($urandom);
            end
            tick();
        end
        bus.px_valid = 1'b0;
        bus.ppu_mode = 2'd0;
        tick();
        tick();
        for (int b = 0; b < (n + 3) / 4; b++) begin
            v = '0;
            for (int k = 0; k < 4; k++) begin
                if (4 * b + k < n) v = v | (8'(sh[4 * b + k]) << (6 - 2 * k));
            end
            exp_addr.push_back(14'(32'(bnk) * 8192 + lnum * 40 + b));
            exp_data.push_back(v);
        end
    endtask

    initial begin
        vec_t        vecs [8];
        logic [13:0] a;
        logic [7:0]  d;
        int          bad;
        int          n;

        vecs[0] = '{bgp: 8'hE4, px: 8'h1B, exp: 8'h1B};
        vecs[1] = '{bgp: 8'h1B, px: 8'h00, exp: 8'hFF};
        vecs[2] = '{bgp: 8'h1B, px: 8'hFF, exp: 8'h00};
        vecs[3] = '{bgp: 8'hE4, px: 8'hFF, exp: 8'hFF};
        vecs[4] = '{bgp: 8'hE4, px: 8'hE4, exp: 8'hE4};
        vecs[5] = '{bgp: 8'h00, px: 8'h1B, exp: 8'h00};
        vecs[6] = '{bgp: 8'hFF, px: 8'h1B, exp: 8'hFF};
        vecs[7] = '{bgp: 8'hD2, px: 8'h1B, exp: 8'h87};

        checks     = 0;
        failures   = 0;
        low_run    = 0;
        ready_rand = 1'b0;
        bus.bgp    = 8'hE4;

        do_reset();
        check("rst_fb_wr", 32'(bus.fb_wr), 32'd0);
        check("rst_fb_addr", 32'(bus.fb_addr), 32'd0);
        check("rst_fb_wdata", 32'(bus.fb_wdata), 32'd0);
        check("rst_frame_done", 32'(bus.frame_done), 32'd0);
        check("rst_bank", 32'(bus.bank), 32'd0);
        check("rst_overflow", 32'(bus.overflow), 32'd0);

        // Palette vectors, one 4-pixel line each
        for (int i = 0; i < 8; i++) begin
            bus.bgp      = vecs[i].bgp;
            bus.ppu_mode = 2'd3;
            for (int k = 0; k < 4; k++) send_px(vecs[i].px[7 - 2 * k -: 2]);
            bus.ppu_mode = 2'd0;
            repeat (3) tick();
            got_at(i, a, d);
            check($sformatf("vec%0d_count", i), 32'(got_addr.size()), 32'(i + 1));
            check($sformatf("vec%0d_addr", i), 32'(a), 32'(i * 40));
            check($sformatf("vec%0d_data", i), 32'(d), 32'(vecs[i].exp));
        end

        // Identity palette, full line
        do_reset();
        bus.bgp      = 8'hE4;
        bus.ppu_mode = 2'd3;
        for (int i = 0; i < 160; i++) send_px(2'(i % 4));
        bus.ppu_mode = 2'd0;
        repeat (4) tick();
        check("id_write_count", 32'(got_addr.size()), 32'd40);
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            got_at(i, a, d);
            if (a !== 14'(i) || d !== 8'h1B) bad++;
        end
        check("id_bytes_wrong", 32'(bad), 32'd0);
        bus.ppu_mode = 2'd3;
        for (int i = 0; i < 4; i++) send_px(2'd0);
        bus.ppu_mode = 2'd0;
        repeat (3) tick();
        got_at(40, a, d);
        check("id_next_line_addr", 32'(a), 32'd40);
        check("id_next_line_data", 32'(d), 32'h00);

        // Backpressure and overflow
        do_reset();
        bus.bgp       = 8'hE4;
        bus.fb_wready = 1'b0;
        bus.ppu_mode  = 2'd3;
        for (int i = 0; i < 3; i++) send_px(2'(i));
        check("bp_wr_before_4th", 32'(bus.fb_wr), 32'd0);
        send_px(2'd3);
        check("bp_wr_after_4th", 32'(bus.fb_wr), 32'd1);
        check("bp_head_addr", 32'(bus.fb_addr), 32'd0);
        check("bp_head_data", 32'(bus.fb_wdata), 32'h1B);
        for (int i = 4; i < 20; i++) send_px(2'(i % 4));
        bus.ppu_mode = 2'd0;
        repeat (2) tick();
        check("bp_overflow_set", 32'(bus.overflow), 32'd1);
        check("bp_no_writes_stalled", 32'(got_addr.size()), 32'd0);
        bus.fb_wready = 1'b1;
        repeat (8) tick();
        check("bp_write_count", 32'(got_addr.size()), 32'd4);
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            got_at(i, a, d);
            if (a !== 14'(i) || d !== 8'h1B) bad++;
        end
        check("bp_bytes_wrong", 32'(bad), 32'd0);
        check("bp_overflow_sticky", 32'(bus.overflow), 32'd1);
        bus.ovf_clr = 1'b1;
        tick();
        bus.ovf_clr = 1'b0;
        tick();
        check("bp_overflow_cleared", 32'(bus.overflow), 32'd0);

        // Short line with zero-padded flush
        do_reset();
        bus.bgp      = 8'hE4;
        bus.ppu_mode = 2'd3;
        for (int i = 0; i < 6; i++) send_px(2'd3);
        bus.ppu_mode = 2'd0;
        repeat (3) tick();
        check("short_write_count", 32'(got_addr.size()), 32'd2);
        got_at(0, a, d);
        check("short_b0_addr", 32'(a), 32'd0);
        check("short_b0_data", 32'(d), 32'hFF);
        got_at(1, a, d);
        check("short_b1_addr", 32'(a), 32'd1);
        check("short_b1_data", 32'(d), 32'hF0);
        bus.ppu_mode = 2'd3;
        for (int i = 0; i < 4; i++) send_px(2'd1);
        bus.ppu_mode = 2'd0;
        repeat (3) tick();
        got_at(2, a, d);
        check("short_next_line_addr", 32'(a), 32'd40);
        check("short_next_line_data", 32'(d), 32'h55);

        // Random full frame with bounded write stalls, then bank swap
        do_reset();
        exp_addr.delete();
        exp_data.delete();
        ready_rand = 1'b1;
        low_run    = 0;
        for (int l = 0; l < 144; l++) begin
            if (l == 143 || l % 9 == 0) n = 160;
            else n = $urandom_range(1, 160);
            run_line(n, l, 1'b0);
        end
        bus.ppu_mode = 2'd1;
        for (int t = 0; t < 300 && fd_cycles == 0; t++) tick();
        repeat (4) tick();
        ready_rand    = 1'b0;
        bus.fb_wready = 1'b1;
        check("frame_done_cycles", 32'(fd_cycles), 32'd1);
        check("frame_done_after_last", 32'(fd_at_writes), 32'(exp_addr.size()));
        check("frame_bank", 32'(bus.bank), 32'd1);
        check("frame_write_count", 32'(got_addr.size()), 32'(exp_addr.size()));
        bad = 0;
        for (int i = 0; i < exp_addr.size(); i++) begin
            got_at(i, a, d);
            if (a !== exp_addr[i] || d !== exp_data[i]) bad++;
        end
        check("frame_bytes_wrong", 32'(bad), 32'd0);
        got_at(exp_addr.size() - 1, a, d);
        check("frame_last_addr", 32'(a), 32'd5759);
        check("frame_no_overflow", 32'(bus.overflow), 32'd0);

        got_addr.delete();
        got_data.delete();
        bus.bgp      = 8'hE4;
        bus.ppu_mode = 2'd2;
        tick();
        bus.ppu_mode = 2'd3;
        for (int i = 0; i < 4; i++) send_px(2'd2);
        repeat (2) tick();
        got_at(0, a, d);
        check("next_frame_addr", 32'(a), 32'h2000);
        check("next_frame_data", 32'(d), 32'hAA);

        // Reset mid-line with a byte pending and a partial byte packed
        got_addr.delete();
        got_data.delete();
        bus.fb_wready = 1'b0;
        for (int i = 0; i < 6; i++) send_px(2'd1);
        check("pre_rst_fb_wr", 32'(bus.fb_wr), 32'd1);
        rst = 1'b1;
        tick();
        check("mid_rst_fb_wr", 32'(bus.fb_wr), 32'd0);
        check("mid_rst_fb_addr", 32'(bus.fb_addr), 32'd0);
        check("mid_rst_fb_wdata", 32'(bus.fb_wdata), 32'd0);
        check("mid_rst_frame_done", 32'(bus.frame_done), 32'd0);
        check("mid_rst_bank", 32'(bus.bank), 32'd0);
        check("mid_rst_overflow", 32'(bus.overflow), 32'd0);
        rst           = 1'b0;
        bus.fb_wready = 1'b1;
        tick();
        bus.ppu_mode = 2'd0;
        repeat (4) tick();
        check("mid_rst_no_writes", 32'(got_addr.size()), 32'd0);

        // Line limit: 144 short lines, then a 145th is dropped
        do_reset();
        for (int l = 0; l < 144; l++) begin
            bus.ppu_mode = 2'd3;
            for (int i = 0; i < 4; i++) send_px(2'd2);
            bus.ppu_mode = 2'd0;
            tick();
        end
        repeat (3) tick();
        check("lim_write_count", 32'(got_addr.size()), 32'd144);
        got_at(143, a, d);
        check("lim_last_addr", 32'(a), 32'd5720);
        check("lim_no_overflow_yet", 32'(bus.overflow), 32'd0);
        got_addr.delete();
        got_data.delete();
        bus.ppu_mode = 2'd3;
        for (int i = 0; i < 8; i++) send_px(2'd1);
        bus.ppu_mode = 2'd0;
        repeat (4) tick();
        check("lim_145_no_writes", 32'(got_addr.size()), 32'd0);
        check("lim_145_overflow", 32'(bus.overflow), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
